sw_sclk_gen: RTL and testbench

Switch-selected, parametrised square-wave/clock generator. It replaces the fixed 8-bit switch-to-maxcount decoder with a complete block: switch synchronisation, a table lookup of the half-period count, a divider counter and a glitch-free output. Selection changes are applied only at half-period boundaries, and silence (selection 0 or out of range) is supported. It sits between the board switches and any slow-clock or tone consumer, such as a speaker pin or a slow-clocked FSM.

---
 rtl/sclk_pkg.sv | 31 +++
 rtl/sw_sclk_gen_sync2.sv | 26 ++
 rtl/sw_sclk_gen.sv | 95 +++++++++
 tb/tb_sw_sclk_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sclk_pkg.sv
// Shared constants for the switch-selected square-wave generator: the note
// table of 100 MHz half-period counts and the selection-to-count lookup.
package sclk_pkg;

  localparam int NOTES_MAX = 37;

  // Index 0 is silence; index 1 is A4 (440 Hz), then chromatic steps upward.
  localparam logic [31:0] TBL [NOTES_MAX] = '{
    32'd0,
    32'd113636, 32'd107257, 32'd101239, 32'd95557,  32'd90193,  32'd85131,
    32'd80353,  32'd75843,  32'd71586,  32'd67569,  32'd63776,  32'd60197,
    32'd56818,  32'd53629,  32'd50619,  32'd47778,  32'd45097,  32'd42566,
    32'd40177,  32'd37922,  32'd35793,  32'd33784,  32'd31888,  32'd30098,
    32'd28409,  32'd26814,  32'd25310,  32'd23889,  32'd22548,  32'd21283,
    32'd20088,  32'd18961,  32'd17897,  32'd16892,  32'd15944,  32'd15049
  };

  // Zero means "no tone"; a real note scaled down to nothing still runs at 1.
  function automatic logic [31:0] sclk_lookup(input logic [31:0] sel,
                                               input int unsigned shift,
                                               input int unsigned notes);
    logic [31:0] v;
    v = '0;
    if (sel != 32'd0 && sel < notes && sel < NOTES_MAX) begin
      v = TBL[sel[5:0]] >> shift;
      if (v == 32'd0) v = 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sw_sclk_gen_sync2.sv
// Generic-width two-flop synchroniser for asynchronous inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sw_sclk_gen.sv
// Switch-selected square-wave generator; selection changes only take effect
// on half-period boundaries so the output never glitches.
module sw_sclk_gen
  import sclk_pkg::*;
#(
  parameter int SW_W        = 8,
  parameter int CNT_W       = 24,
  parameter int NOTES       = 37,
  parameter int SCALE_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SW_W-1:0]  SW,
  input  logic             EN,
  output logic             SCLK,
  output logic             TICK,
  output logic             ACTIVE,
  output logic [CNT_W-1:0] MAXCOUNT
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [SW_W-1:0]  sel;
  logic [CNT_W-1:0] next_max;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;

  sync2 #(.W(SW_W)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (SW),
    .q_o   (sel)
  );

  assign next_max = CNT_W'(sclk_lookup(32'(sel), SCALE_SHIFT, NOTES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    sclk_d  = sclk_q;
    tick_d  = 1'b0;
    if (EN) begin
      if (state_q == ST_IDLE) begin
        if (next_max != '0) begin
          max_d   = next_max;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end else if (cnt_q == max_q - CNT_W'(1)) begin
        // Boundary: the only place a new selection (or silence) is applied.
        cnt_d = '0;
        if (next_max != '0) begin
          sclk_d = ~sclk_q;
          tick_d = 1'b1;
          max_d  = next_max;
        end else begin
          sclk_d  = 1'b0;
          tick_d  = sclk_q;
          max_d   = '0;
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      sclk_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      sclk_q  <= sclk_d;
      tick_q  <= tick_d;
    end
  end

  assign SCLK     = sclk_q;
  assign TICK     = tick_q;
  assign ACTIVE   = (state_q == ST_RUN);
  assign MAXCOUNT = max_q;

endmodule

// File: tb/tb_sw_sclk_gen.sv
// Self-checking bench for sw_sclk_gen: a scaled instance (shift 12) and a
// clamped instance (shift 20) driven from one clock.
module tb_sw_sclk_gen;

  localparam int SW_W  = 8;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst, en, sclk, tick, active;
  logic [SW_W-1:0]  sw;
  logic [CNT_W-1:0] maxc;
  logic             rst2, en2, sclk2, tick2, active2;
  logic [SW_W-1:0]  sw2;
  logic [CNT_W-1:0] maxc2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_tick = 0;

  typedef struct {
    int   half;
    logic lvl;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sw_sclk_gen #(.SW_W(SW_W), .CNT_W(CNT_W), .NOTES(37), .SCALE_SHIFT(12)) u_dut (
    .CLK(clk), .RST(rst), .SW(sw), .EN(en),
    .SCLK(sclk), .TICK(tick), .ACTIVE(active), .MAXCOUNT(maxc)
  );

  sw_sclk_gen #(.SW_W(SW_W), .CNT_W(CNT_W), .NOTES(37), .SCALE_SHIFT(20)) u_dut20 (
    .CLK(clk), .RST(rst2), .SW(sw2), .EN(en2),
    .SCLK(sclk2), .TICK(tick2), .ACTIVE(active2), .MAXCOUNT(maxc2)
  );

  // Waits for the next TICK (sampled at negedge); returns the cycles since the
  // previous TICK, or -1 if none arrives within maxn cycles.
  task automatic wait_tick(input int maxn, output int half);
    int n;
    n = 0;
    half = -1;
    while (n < maxn) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) begin
        half = cyc - last_tick;
        last_tick = cyc;
        break;
      end
    end
  endtask

  task automatic wait_active(input logic lvl, input int maxn, output int n);
    n = 0;
    while (active !== lvl && n < maxn) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int h;
    rst = 1'b1; sw = 8'd1; en = 1'b1;
    rst2 = 1'b1; sw2 = 8'd0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    total++; if (maxc !== '0) begin bad++; $display("FAIL reset_maxcount got=%0d exp=0", maxc); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (maxc !== '0) begin bad++; $display("FAIL reset_early_load got=%0d exp=0", maxc); end
    @(negedge clk);
    total++; if (maxc !== 24'd27) begin bad++; $display("FAIL reset_load3 got=%0d exp=27", maxc); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL reset_active_run got=%b exp=1", active); end
    last_tick = cyc;
    exp_q.push_back('{27, 1'b1}); exp_q.push_back('{27, 1'b0});
    exp_q.push_back('{27, 1'b1}); exp_q.push_back('{27, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL reset_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL reset_level got=%b exp=%b", sclk, e.lvl); end
    end
  endtask

  task automatic test_midrun();
    exp_t e;
    int h;
    repeat (10) @(negedge clk);
    sw = 8'd13;
    exp_q.push_back('{27, 1'b1}); exp_q.push_back('{13, 1'b0});
    exp_q.push_back('{13, 1'b1}); exp_q.push_back('{13, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL midrun_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL midrun_level got=%b exp=%b", sclk, e.lvl); end
    end
    total++; if (maxc !== 24'd13) begin bad++; $display("FAIL midrun_maxcount got=%0d exp=13", maxc); end
  endtask

  task automatic test_silence();
    exp_t e;
    int h, n, ticks;
    exp_q.push_back('{13, 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL silence_pre_half got=%0d exp=%0d", h, e.half); end
    end
    // SCLK is high: silence must produce a final falling TICK.
    sw = 8'd0;
    exp_q.push_back('{13, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL silence_fall_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL silence_fall_level got=%b exp=%b", sclk, e.lvl); end
    end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL silence_active got=%b exp=0", active); end
    total++; if (maxc !== '0) begin bad++; $display("FAIL silence_maxcount got=%0d exp=0", maxc); end
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick !== 1'b0 || sclk !== 1'b0) ticks++;
    end
    total++; if (ticks !== 0) begin bad++; $display("FAIL silence_idle_quiet got=%0d exp=0", ticks); end
    // Restart, then go out of range while SCLK is low.
    sw = 8'd1;
    wait_active(1'b1, 10, n);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL silence_restart got=%b exp=1", active); end
    last_tick = cyc;
    exp_q.push_back('{27, 1'b1}); exp_q.push_back('{27, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL silence_restart_half got=%0d exp=%0d", h, e.half); end
    end
    sw = 8'hFF;
    ticks = 0;
    n = 0;
    while (active !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
      if (tick !== 1'b0) ticks++;
    end
    total++; if (cyc - last_tick !== 27) begin bad++; $display("FAIL oor_stop_cycle got=%0d exp=27", cyc - last_tick); end
    total++; if (ticks !== 0) begin bad++; $display("FAIL oor_tick got=%0d exp=0", ticks); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL oor_sclk got=%b exp=0", sclk); end
    total++; if (maxc !== '0) begin bad++; $display("FAIL oor_maxcount got=%0d exp=0", maxc); end
  endtask

  task automatic test_enable();
    exp_t e;
    int h, n, errs;
    logic snap;
    sw = 8'd1;
    wait_active(1'b1, 10, n);
    last_tick = cyc;
    exp_q.push_back('{27, 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL enable_first_half got=%0d exp=%0d", h, e.half); end
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
    snap = sclk;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick !== 1'b0 || sclk !== snap || maxc !== 24'd27) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL enable_freeze got=%0d exp=0", errs); end
    en = 1'b1;
    exp_q.push_back('{37, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL enable_stretched_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL enable_stretched_level got=%b exp=%b", sclk, e.lvl); end
    end
    // Park on the boundary cycle with EN low.
    repeat (26) @(negedge clk);
    en = 1'b0;
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (tick !== 1'b0 || sclk !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL enable_boundary_hold got=%0d exp=0", errs); end
    en = 1'b1;
    exp_q.push_back('{32, 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL enable_boundary_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL enable_boundary_level got=%b exp=%b", sclk, e.lvl); end
    end
  endtask

  task automatic test_clamp();
    logic lvl_q[$];
    logic lvl, got_lvl;
    int n;
    sw2 = 8'd13; en2 = 1'b1;
    rst2 = 1'b0;
    n = 0;
    while (active2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (maxc2 !== 24'd1) begin bad++; $display("FAIL clamp_maxcount got=%0d exp=1", maxc2); end
    lvl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lvl = ~lvl;
      lvl_q.push_back(lvl);
      @(negedge clk);
      got_lvl = lvl_q.pop_front();
      total++; if (sclk2 !== got_lvl) begin bad++; $display("FAIL clamp_toggle[%0d] got=%b exp=%b", i, sclk2, got_lvl); end
      total++; if (tick2 !== 1'b1) begin bad++; $display("FAIL clamp_tick[%0d] got=%b exp=1", i, tick2); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int h;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL areset_sclk got=%b exp=0", sclk); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL areset_tick got=%b exp=0", tick); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL areset_active got=%b exp=0", active); end
    total++; if (maxc !== '0) begin bad++; $display("FAIL areset_maxcount got=%0d exp=0", maxc); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (maxc !== '0) begin bad++; $display("FAIL areset_early_load got=%0d exp=0", maxc); end
    @(negedge clk);
    total++; if (maxc !== 24'd27) begin bad++; $display("FAIL areset_load3 got=%0d exp=27", maxc); end
    last_tick = cyc;
    exp_q.push_back('{27, 1'b1}); exp_q.push_back('{27, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(e.half + 20, h);
      total++; if (h !== e.half) begin bad++; $display("FAIL areset_half got=%0d exp=%0d", h, e.half); end
      total++; if (sclk !== e.lvl) begin bad++; $display("FAIL areset_level got=%b exp=%b", sclk, e.lvl); end
    end
  endtask

  initial begin
    test_reset();
    test_midrun();
    test_silence();
    test_enable();
    test_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
